// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: two-client req/gnt front end for the ram128m dual-read/single-write RAM.
// Optional same-cycle write-to-read forwarding is built when RAM_ARB_BYPASS_EN is defined.
module ram_access_arbiter #(
    parameter int AW     = 27,
    parameter int DW     = 16,
    parameter int RD_LAT = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c0_req,
    input  logic          c1_req,
    input  logic          c0_we,
    input  logic          c1_we,
    input  logic [AW-1:0] c0_addr,
    input  logic [AW-1:0] c1_addr,
    input  logic [DW-1:0] c0_wdata,
    input  logic [DW-1:0] c1_wdata,
    output logic          c0_gnt,
    output logic          c1_gnt,
    output logic          c0_rvalid,
    output logic          c1_rvalid,
    output logic [DW-1:0] c0_rdata,
    output logic [DW-1:0] c1_rdata,
    output logic          ram_wr,
    output logic [AW-1:0] ram_wr_addr,
    output logic [DW-1:0] ram_d_in,
    output logic [AW-1:0] ram_rd_addr_a,
    output logic [AW-1:0] ram_rd_addr_b,
    input  logic [DW-1:0] ram_d_out_a,
    input  logic [DW-1:0] ram_d_out_b
);

    logic          c0_wr_req, c1_wr_req;
    logic          c0_rd_gnt, c1_rd_gnt;
    logic          c0_wr_gnt, c1_wr_gnt;

    logic          prio_q, prio_d;
    logic          ram_wr_q, ram_wr_d;
    logic [AW-1:0] ram_wr_addr_q, ram_wr_addr_d;
    logic [DW-1:0] ram_d_in_q, ram_d_in_d;
    logic [AW-1:0] rd_addr_a_q, rd_addr_a_d;
    logic [AW-1:0] rd_addr_b_q, rd_addr_b_d;
    logic [RD_LAT:0] rv0_q, rv0_d;
    logic [RD_LAT:0] rv1_q, rv1_d;

    // prio_q names the client that wins when both want the single write port.
    always_comb begin
        c0_wr_req = c0_req & c0_we;
        c1_wr_req = c1_req & c1_we;
        c0_rd_gnt = reset & c0_req & ~c0_we;
        c1_rd_gnt = reset & c1_req & ~c1_we;
        c0_wr_gnt = reset & c0_wr_req & (~c1_wr_req | ~prio_q);
        c1_wr_gnt = reset & c1_wr_req & (~c0_wr_req | prio_q);
    end

    assign c0_gnt = c0_rd_gnt | c0_wr_gnt;
    assign c1_gnt = c1_rd_gnt | c1_wr_gnt;

    always_comb begin
        prio_d        = prio_q;
        ram_wr_d      = c0_wr_gnt | c1_wr_gnt;
        ram_wr_addr_d = ram_wr_addr_q;
        ram_d_in_d    = ram_d_in_q;
        if (c0_wr_gnt) begin
            prio_d        = 1'b1;
            ram_wr_addr_d = c0_addr;
            ram_d_in_d    = c0_wdata;
        end else if (c1_wr_gnt) begin
            prio_d        = 1'b0;
            ram_wr_addr_d = c1_addr;
            ram_d_in_d    = c1_wdata;
        end
        rd_addr_a_d = c0_rd_gnt ? c0_addr : rd_addr_a_q;
        rd_addr_b_d = c1_rd_gnt ? c1_addr : rd_addr_b_q;
    end

    // rvalid pipelines track the RAM read latency so the strobe lines up with d_out.
    always_comb begin
        rv0_d    = rv0_q;
        rv1_d    = rv1_q;
        rv0_d[0] = c0_rd_gnt;
        rv1_d[0] = c1_rd_gnt;
        for (int i = 1; i <= RD_LAT; i++) begin
            rv0_d[i] = rv0_q[i-1];
            rv1_d[i] = rv1_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q        <= 1'b0;
            ram_wr_q      <= 1'b0;
            ram_wr_addr_q <= '0;
            ram_d_in_q    <= '0;
            rd_addr_a_q   <= '0;
            rd_addr_b_q   <= '0;
            rv0_q         <= '0;
            rv1_q         <= '0;
        end else begin
            prio_q        <= prio_d;
            ram_wr_q      <= ram_wr_d;
            ram_wr_addr_q <= ram_wr_addr_d;
            ram_d_in_q    <= ram_d_in_d;
            rd_addr_a_q   <= rd_addr_a_d;
            rd_addr_b_q   <= rd_addr_b_d;
            rv0_q         <= rv0_d;
            rv1_q         <= rv1_d;
        end
    end

    assign ram_wr        = ram_wr_q;
    assign ram_wr_addr   = ram_wr_addr_q;
    assign ram_d_in      = ram_d_in_q;
    assign ram_rd_addr_a = rd_addr_a_q;
    assign ram_rd_addr_b = rd_addr_b_q;
    assign c0_rvalid     = rv0_q[RD_LAT];
    assign c1_rvalid     = rv1_q[RD_LAT];

`ifdef RAM_ARB_BYPASS_EN
    logic [RD_LAT:0] byp0_q, byp0_d;
    logic [RD_LAT:0] byp1_q, byp1_d;
    logic [DW-1:0]   bdat0_q [RD_LAT:0];
    logic [DW-1:0]   bdat0_d [RD_LAT:0];
    logic [DW-1:0]   bdat1_q [RD_LAT:0];
    logic [DW-1:0]   bdat1_d [RD_LAT:0];

    // A read colliding with the other client's granted write carries that write's data along.
    always_comb begin
        byp0_d     = byp0_q;
        byp1_d     = byp1_q;
        bdat0_d    = bdat0_q;
        bdat1_d    = bdat1_q;
        byp0_d[0]  = c0_rd_gnt & c1_wr_gnt & (c0_addr == c1_addr);
        byp1_d[0]  = c1_rd_gnt & c0_wr_gnt & (c1_addr == c0_addr);
        bdat0_d[0] = c1_wdata;
        bdat1_d[0] = c0_wdata;
        for (int i = 1; i <= RD_LAT; i++) begin
            byp0_d[i]  = byp0_q[i-1];
            byp1_d[i]  = byp1_q[i-1];
            bdat0_d[i] = bdat0_q[i-1];
            bdat1_d[i] = bdat1_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byp0_q <= '0;
            byp1_q <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                bdat0_q[i] <= '0;
                bdat1_q[i] <= '0;
            end
        end else begin
            byp0_q  <= byp0_d;
            byp1_q  <= byp1_d;
            bdat0_q <= bdat0_d;
            bdat1_q <= bdat1_d;
        end
    end

    assign c0_rdata = byp0_q[RD_LAT] ? bdat0_q[RD_LAT] : ram_d_out_a;
    assign c1_rdata = byp1_q[RD_LAT] ? bdat1_q[RD_LAT] : ram_d_out_b;
`else
    assign c0_rdata = ram_d_out_a;
    assign c1_rdata = ram_d_out_b;
`endif

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter: a behavioural RAM plus a reference model of the
// access rules predicts grants, RAM write beats and per-client read data with arrival cycles.
module tb_ram_access_arbiter;
    localparam int AW     = 27;
    localparam int DW     = 16;
    localparam int RD_LAT = 0;

    typedef struct {
        logic [AW+DW-1:0] val;
        int               cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_v, we_v;
    logic [AW-1:0] addr_v  [2];
    logic [DW-1:0] wdata_v [2];
    logic          c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
    logic [DW-1:0] c0_rdata, c1_rdata;
    logic          ram_wr;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr_a, ram_rd_addr_b;
    logic [DW-1:0] ram_d_in, ram_d_out_a, ram_d_out_b;

    logic [DW-1:0] tb_mem [0:15];
    logic          mem_clear;

    logic [DW-1:0] ref_mem [0:15];
    int            ref_prio;
    int            cyc_cnt = 0;
    exp_t          exp_rd0[$], exp_rd1[$], exp_wr[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_access_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .c0_req(req_v[0]), .c1_req(req_v[1]),
        .c0_we(we_v[0]), .c1_we(we_v[1]),
        .c0_addr(addr_v[0]), .c1_addr(addr_v[1]),
        .c0_wdata(wdata_v[0]), .c1_wdata(wdata_v[1]),
        .c0_gnt(c0_gnt), .c1_gnt(c1_gnt),
        .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid),
        .c0_rdata(c0_rdata), .c1_rdata(c1_rdata),
        .ram_wr(ram_wr), .ram_wr_addr(ram_wr_addr), .ram_d_in(ram_d_in),
        .ram_rd_addr_a(ram_rd_addr_a), .ram_rd_addr_b(ram_rd_addr_b),
        .ram_d_out_a(ram_d_out_a), .ram_d_out_b(ram_d_out_b)
    );

    // Behavioural ram128m slice: combinational read, write at the end of the ram_wr cycle.
    assign ram_d_out_a = tb_mem[ram_rd_addr_a[3:0]];
    assign ram_d_out_b = tb_mem[ram_rd_addr_b[3:0]];

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) tb_mem[i] <= '0;
        end else if (ram_wr) begin
            tb_mem[ram_wr_addr[3:0]] <= ram_d_in;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pop_chk(input string name, inout exp_t q[$], input logic [AW+DW-1:0] act);
        exp_t e;
        if (q.size() == 0) begin
            chk({name, "_unexpected"}, 64'(act), 64'hDEAD_0000_0000);
        end else begin
            e = q.pop_front();
            chk(name, 64'(act), 64'(e.val));
            chk({name, "_cycle"}, 64'(cyc_cnt), 64'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (c0_rvalid) pop_chk("c0_rdata", exp_rd0, {{AW{1'b0}}, c0_rdata});
            if (c1_rvalid) pop_chk("c1_rdata", exp_rd1, {{AW{1'b0}}, c1_rdata});
            if (ram_wr)    pop_chk("ram_write", exp_wr, {ram_wr_addr, ram_d_in});
        end
    end

    // One clock cycle: predict grants from the access rules, check them, and queue the results.
    task automatic step(output logic [1:0] granted);
        int            winner;
        logic [DW-1:0] d;
        exp_t          e;
        #3;
        winner = -1;
        if (req_v[0] && we_v[0] && req_v[1] && we_v[1]) winner = ref_prio;
        else if (req_v[0] && we_v[0])                   winner = 0;
        else if (req_v[1] && we_v[1])                   winner = 1;
        for (int c = 0; c < 2; c++)
            granted[c] = req_v[c] && (!we_v[c] || winner == c);
        chk("c0_gnt", 64'(c0_gnt), 64'(granted[0]));
        chk("c1_gnt", 64'(c1_gnt), 64'(granted[1]));
        for (int c = 0; c < 2; c++) begin
            if (req_v[c] && !we_v[c]) begin
                d = ref_mem[addr_v[c][3:0]];
`ifdef RAM_ARB_BYPASS_EN
                if (winner == 1 - c && addr_v[winner] == addr_v[c]) d = wdata_v[winner];
`endif
                e.val = {{AW{1'b0}}, d};
                e.cyc = cyc_cnt + 1 + RD_LAT;
                if (c == 0) exp_rd0.push_back(e);
                else        exp_rd1.push_back(e);
            end
        end
        if (winner >= 0) begin
            e.val = {addr_v[winner], wdata_v[winner]};
            e.cyc = cyc_cnt + 1;
            exp_wr.push_back(e);
            ref_mem[addr_v[winner][3:0]] = wdata_v[winner];
            ref_prio = 1 - winner;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_v[c]   = r;
        we_v[c]    = w;
        addr_v[c]  = a;
        wdata_v[c] = d;
    endtask

    task automatic idle(input int n);
        logic [1:0] g;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < n; i++) step(g);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_c0_gnt"}, 64'(c0_gnt), 64'd0);
        chk({tag, "_c1_gnt"}, 64'(c1_gnt), 64'd0);
        chk({tag, "_ram_wr"}, 64'(ram_wr), 64'd0);
        chk({tag, "_ram_wr_addr"}, 64'(ram_wr_addr), 64'd0);
        chk({tag, "_ram_d_in"}, 64'(ram_d_in), 64'd0);
        chk({tag, "_rd_addr_a"}, 64'(ram_rd_addr_a), 64'd0);
        chk({tag, "_rd_addr_b"}, 64'(ram_rd_addr_b), 64'd0);
        chk({tag, "_c0_rvalid"}, 64'(c0_rvalid), 64'd0);
        chk({tag, "_c1_rvalid"}, 64'(c1_rvalid), 64'd0);
    endtask

    initial begin
        logic [1:0] g;
        reset     = 1'b0;
        mem_clear = 1'b1;
        set_req(0, 1'b1, 1'b0, 27'h5, '0);
        set_req(1, 1'b1, 1'b1, 27'h6, 16'h7777);
        ref_prio = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_outputs("por");
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        reset     = 1'b1;
        mem_clear = 1'b0;

        // Both clients write from reset state, held two cycles: c0 wins first, c1 next.
        set_req(0, 1'b1, 1'b1, 27'h2, 16'h1234);
        set_req(1, 1'b1, 1'b1, 27'h3, 16'h5678);
        step(g);
        step(g);
        idle(1);

        set_req(0, 1'b1, 1'b1, 27'h1, 16'hABCD);
        step(g);
        idle(1);
        set_req(0, 1'b1, 1'b0, 27'h1, '0);
        step(g);
        idle(1);

        set_req(0, 1'b1, 1'b0, 27'h1, '0);
        set_req(1, 1'b1, 1'b0, 27'h2, '0);
        step(g);
        idle(1);

        // Same-cycle collision: c1 writes the address c0 is reading.
        set_req(0, 1'b1, 1'b0, 27'h1, '0);
        set_req(1, 1'b1, 1'b1, 27'h1, 16'hBEEF);
        step(g);
        idle(2);

        // Leave prio on client 1, then reset just after a read is accepted.
        set_req(0, 1'b1, 1'b1, 27'h4, 16'h1111);
        step(g);
        idle(2);
        set_req(0, 1'b1, 1'b0, 27'h4, '0);
        step(g);
        reset = 1'b0;
        exp_rd0.delete();
        exp_rd1.delete();
        exp_wr.delete();
        ref_prio = 0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_outputs("midrst_hold");
        set_req(0, 1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        idle(1);

        // prio must be back on client 0 after reset.
        set_req(0, 1'b1, 1'b1, 27'h5, 16'h2222);
        set_req(1, 1'b1, 1'b1, 27'h6, 16'h3333);
        step(g);
        chk("prio_after_reset", 64'(g), 64'b01);
        set_req(0, 1'b0, 1'b0, '0, '0);
        step(g);
        idle(2);

        // Randomised traffic; each client holds its request until granted.
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < 2; c++) begin
                if (!req_v[c] && $urandom_range(0, 3) != 0)
                    set_req(c, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                            DW'($urandom));
            end
            step(g);
            for (int c = 0; c < 2; c++)
                if (g[c]) req_v[c] = 1'b0;
        end
        idle(4);
        chk("rd0_drain", 64'(exp_rd0.size()), 64'd0);
        chk("rd1_drain", 64'(exp_rd1.size()), 64'd0);
        chk("wr_drain", 64'(exp_wr.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
